uart_bus_master: RTL and testbench
==================================

// Module: uart_bus_master
// PURPOSE
// - Debug/boot bridge: a host drives the SoC memory bus over the serial byte link.
// - Decodes byte commands from the UART receive side and issues single-word
//   transactions as an initiator on the native valid/ready memory bus.
// - Returns read data or ACK/NAK bytes to the UART transmit side.
// - Sits beside the CPU core; a bus arbiter (outside this block) grants the bus.
// PARAMETERS
// TIMEOUT      1024  cycles to wait for mem_ready before abort (>=2)
// ALIGN_CHECK  1     1: NAK any address with addr[1:0]!=0, no bus access
// PORTS
// clk        in   1   system clock
// rst        in   1   synchronous reset, active-high
// rx_valid   in   1   one-cycle strobe: rx_data holds a received byte
// rx_data    in   8   received byte
// tx_valid   out  1   tx_data is valid; held until tx_ready
// tx_data    out  8   byte to transmit; stable while tx_valid && !tx_ready
// tx_ready   in   1   transmitter accepts the byte this cycle
// mem_valid  out  1   bus request
// mem_ready  in   1   responder done; rdata valid this cycle on reads
// mem_addr   out  32  byte address
// mem_wdata  out  32  write data
// mem_wstrb  out  4   4'b1111 on write, 4'b0000 on read
// mem_rdata  in   32  read data
// busy       out  1   high in every state except IDLE
// overrun    out  1   sticky: rx byte arrived in BUS/RESP; cleared only by rst
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; assembly regs and byte counter cleared.
// - rst mid-command/mid-bus: abort at once; mem_valid and tx_valid low next cycle.
// - Protocol (multi-byte fields little-endian):
//   0x52 'R' a0..a3  -> bus read  -> reply d0..d3
//   0x57 'W' a0..a3 d0..d3 -> bus write -> reply 0x06 ACK
//   other opcode -> reply 0x15 NAK; no extra bytes consumed
// - FSM: IDLE -> ADDR -> (write) DATA -> BUS -> RESP -> IDLE.
//   - IDLE: valid opcode -> ADDR, cnt=0; invalid opcode -> RESP (NAK).
//   - ADDR/DATA: each rx byte shifts into bits [8*cnt+:8]; after byte 3 advance.
//   - ADDR end, ALIGN_CHECK=1, addr[1:0]!=0 -> RESP (NAK), no bus cycle.
//   - BUS: mem_valid=1 the cycle after entry; addr/wdata/wstrb stable while valid.
//     - mem_ready sampled high -> capture rdata; mem_valid low next cycle; go RESP.
//     - mem_ready never high for TIMEOUT cycles -> drop mem_valid; go RESP (NAK).
//   - RESP: present bytes in order; advance only on tx_valid&&tx_ready.
//     - Read reply is 4 bytes; ACK/NAK is 1 byte; last accepted byte -> IDLE.
// - rx_valid in BUS/RESP: byte dropped, overrun<=1.
// - No inter-byte timeout; the host resyncs by sending NAK-producing bytes.
// - mem_ready while mem_valid is low: ignored.
// - Timeout counter: 0 on BUS entry; saturates at TIMEOUT-1; no wrap.
// - Latency: last command byte -> mem_valid = 1 cycle;
//   mem_ready -> first tx_valid = 1 cycle.
// STRUCTURE
// - Package uart_bus_master_pkg: opcodes OP_READ=8'h52, OP_WRITE=8'h57;
//   reply codes RSP_ACK=8'h06, RSP_NAK=8'h15; state enum.
// - One sub-module, bus_timeout: counter with clr/en inputs and expired output.
// TESTING
// - Write: 57 10 00 00 00 EF BE AD DE -> mem_valid, addr 0x10, wdata 0xDEADBEEF,
//   wstrb F; ready after 3 cycles -> tx 0x06.
// - Read: 52 00 04 00 00, rdata 0x12345678 -> tx 78 56 34 12; tx_ready
//   stalls hold tx_data stable.
// - Bad opcode 0x41 -> tx 0x15, no mem_valid; next valid command works.
// - Unaligned: 52 02 00 00 00 with ALIGN_CHECK=1 -> 0x15, no mem_valid.
// - Timeout: read, mem_ready held 0 -> mem_valid low after TIMEOUT cycles,
//   tx 0x15.
// - Overrun: byte during BUS -> overrun=1, transaction completes normally.
// - rst asserted mid-BUS -> mem_valid=0, busy=0 next cycle.

Source files
------------

// File: rtl/uart_bus_master_pkg.sv
// ============================================================
// uart_bus_master_pkg : opcodes, reply codes and FSM states
// Rev 1.0
// ============================================================
`default_nettype none

package uart_bus_master_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_bus_master_if.sv
// ============================================================
// uart_bus_master_if : UART byte streams and memory-bus initiator
// Rev 1.0
// ============================================================
`default_nettype none

interface uart_bus_master_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  rx_valid, rx_data, tx_ready, mem_ready, mem_rdata,
    output tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, mem_ready, mem_rdata,
    input  tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

`default_nettype wire

// File: rtl/uart_bus_master_bus_timeout.sv
// ============================================================
// bus_timeout : saturating wait counter, expired at TIMEOUT-1
// Rev 1.0
// ============================================================
`default_nettype none

module bus_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int            W    = $clog2(TIMEOUT);
  localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);
endmodule

`default_nettype wire

// File: rtl/uart_bus_master.sv
// ============================================================
// uart_bus_master : UART byte commands -> single-word bus transactions
// Rev 1.0
// ============================================================
`default_nettype none

module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int TIMEOUT     = 1024,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  uart_bus_master_if.master bus,
  output logic              busy,
  output logic              overrun
);
  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n, last, last_n;
  logic [31:0] addr, addr_n, wdata, wdata_n, resp, resp_n;
  logic        is_write, is_write_n, overrun_n;
  logic        expired;

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_BUS),
    .en      (state == ST_BUS),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last     <= '0;
      addr     <= '0;
      wdata    <= '0;
      resp     <= '0;
      is_write <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      resp     <= resp_n;
      is_write <= is_write_n;
      overrun  <= overrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_n     = last;
    addr_n     = addr;
    wdata_n    = wdata;
    resp_n     = resp;
    is_write_n = is_write;
    overrun_n  = overrun;
    unique case (state)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          cnt_n = '0;
          if (bus.rx_data == OP_READ || bus.rx_data == OP_WRITE) begin
            is_write_n = (bus.rx_data == OP_WRITE);
            state_n    = ST_ADDR;
          end else begin
            resp_n  = {24'h0, RSP_NAK};
            last_n  = 2'd0;
            state_n = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (bus.rx_valid) begin
          addr_n[{cnt, 3'b000} +: 8] = bus.rx_data;
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) begin
            // Unaligned addresses are refused before any data bytes are taken
            if (ALIGN_CHECK && addr_n[1:0] != 2'b00) begin
              resp_n  = {24'h0, RSP_NAK};
              last_n  = 2'd0;
              state_n = ST_RESP;
            end else if (is_write) begin
              state_n = ST_DATA;
            end else begin
              state_n = ST_BUS;
            end
          end
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          wdata_n[{cnt, 3'b000} +: 8] = bus.rx_data;
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) state_n = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus.rx_valid) overrun_n = 1'b1;
        if (bus.mem_ready) begin
          resp_n  = is_write ? {24'h0, RSP_ACK} : bus.mem_rdata;
          last_n  = is_write ? 2'd0 : 2'd3;
          cnt_n   = '0;
          state_n = ST_RESP;
        end else if (expired) begin
          resp_n  = {24'h0, RSP_NAK};
          last_n  = 2'd0;
          cnt_n   = '0;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rx_valid) overrun_n = 1'b1;
        if (bus.tx_ready) begin
          if (cnt == last) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end else begin
            cnt_n = cnt + 2'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy          = (state != ST_IDLE);
  assign bus.mem_valid = (state == ST_BUS);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_wstrb = (state == ST_BUS && is_write) ? 4'hF : 4'h0;
  assign bus.tx_valid  = (state == ST_RESP);
  assign bus.tx_data   = (state == ST_RESP) ? resp[{cnt, 3'b000} +: 8] : 8'h00;
endmodule

`default_nettype wire

// File: tb/tb_uart_bus_master.sv
// ============================================================
// tb_uart_bus_master : vector table, corner sequences, random vs model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_uart_bus_master;
  import uart_bus_master_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int LIMIT   = 4 * TIMEOUT + 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, overrun;

  always #5 clk = ~clk;

  uart_bus_master_if bif();

  uart_bus_master #(.TIMEOUT(TIMEOUT), .ALIGN_CHECK(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .busy    (busy),
    .overrun (overrun)
  );

  typedef struct {
    logic [71:0] cmd;
    int          ncmd;
    int          delay;   // mem_ready delay in cycles, -1 = never
    bit          stall;
    logic [31:0] tx;
    int          ntx;
    int          run;     // expected mem_valid high length, 0 = no bus cycle
    bit          txn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk_read(input logic [31:0] a);
    return {32'h0, a, OP_READ};
  endfunction

  function automatic logic [71:0] mk_write(input logic [31:0] a, input logic [31:0] d);
    return {d, a, OP_WRITE};
  endfunction

  // Responder memory and the independent reference copy for the random phase
  logic [31:0] mem_arr   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : ~a;
  endfunction

  function automatic logic [31:0] model_get(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : ~a;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          ready_delay = 0;
  bit          stall = 1'b0;
  int          mv_len = 0, last_run = 0;
  int          ready_cyc = -10, tx_rise_cyc = -20;
  logic [31:0] mv_addr, mv_wdata;
  logic [3:0]  mv_wstrb;
  bit          tx_prev_valid = 1'b0, tx_stalled = 1'b0;
  logic [7:0]  tx_prev_data;
  logic [7:0]  tx_q[$];
  logic [31:0] txn_addr[$], txn_wdata[$];
  logic [3:0]  txn_wstrb[$];

  // Bus responder and UART transmit sink, both acting on the falling edge
  always @(negedge clk) begin
    bit rdy;
    if (bif.mem_valid) begin
      if (mv_len == 0) begin
        mv_addr  = bif.mem_addr;
        mv_wdata = bif.mem_wdata;
        mv_wstrb = bif.mem_wstrb;
      end else begin
        check("mem_addr_hold", bif.mem_addr, mv_addr);
        check("mem_wdata_hold", bif.mem_wdata, mv_wdata);
        check("mem_wstrb_hold", {28'h0, bif.mem_wstrb}, {28'h0, mv_wstrb});
      end
      rdy = (ready_delay >= 0) && (mv_len == ready_delay);
      mv_len++;
      bif.mem_ready = rdy;
      bif.mem_rdata = rdy ? mem_get(bif.mem_addr) : $urandom();
      if (rdy) begin
        txn_addr.push_back(bif.mem_addr);
        txn_wdata.push_back(bif.mem_wdata);
        txn_wstrb.push_back(bif.mem_wstrb);
        ready_cyc = cyc;
        if (bif.mem_wstrb == 4'hF) mem_arr[bif.mem_addr] = bif.mem_wdata;
      end
    end else begin
      if (mv_len != 0) last_run = mv_len;
      mv_len        = 0;
      bif.mem_ready = 1'($urandom_range(0, 1));
      bif.mem_rdata = $urandom();
    end

    if (tx_stalled && !rst) check("tx_valid_hold", {31'h0, bif.tx_valid}, 32'h1);
    if (bif.tx_valid) begin
      if (!tx_prev_valid) tx_rise_cyc = cyc;
      if (tx_stalled) check("tx_data_hold", {24'h0, bif.tx_data}, {24'h0, tx_prev_data});
      bif.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bif.tx_ready) tx_q.push_back(bif.tx_data);
      tx_stalled   = !bif.tx_ready;
      tx_prev_data = bif.tx_data;
    end else begin
      tx_stalled   = 1'b0;
      bif.tx_ready = 1'($urandom_range(0, 1));
    end
    tx_prev_valid = bif.tx_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    @(negedge clk);
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'($urandom());
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s idle", tag), {31'h0, busy}, 32'h0);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int gap;
    tx_q.delete();
    txn_addr.delete();
    txn_wdata.delete();
    txn_wstrb.delete();
    last_run    = 0;
    ready_delay = v.delay;
    stall       = v.stall;
    for (int i = 0; i < v.ncmd; i++) begin
      if (v.stall) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
      end
      send_byte(v.cmd[8*i +: 8]);
    end
    if (v.run > 0) check($sformatf("%s cmd_to_valid", tag), {31'h0, bif.mem_valid}, 32'h1);
    else           check($sformatf("%s no_bus", tag), {31'h0, bif.mem_valid}, 32'h0);
    wait_idle(tag);
    @(negedge clk);
    check($sformatf("%s ntx", tag), tx_q.size(), v.ntx);
    for (int i = 0; i < v.ntx && i < tx_q.size(); i++)
      check($sformatf("%s tx%0d", tag, i), {24'h0, tx_q[i]}, {24'h0, v.tx[8*i +: 8]});
    check($sformatf("%s ntxn", tag), txn_addr.size(), {31'h0, v.txn});
    if (v.txn && txn_addr.size() > 0) begin
      check($sformatf("%s addr", tag), txn_addr[0], v.addr);
      check($sformatf("%s wstrb", tag), {28'h0, txn_wstrb[0]}, {28'h0, v.wstrb});
      if (v.wstrb == 4'hF) check($sformatf("%s wdata", tag), txn_wdata[0], v.wdata);
      check($sformatf("%s ready_to_tx", tag), tx_rise_cyc - ready_cyc, 32'd1);
    end
    check($sformatf("%s run", tag), last_run, v.run);
    check($sformatf("%s overrun", tag), {31'h0, overrun}, 32'h0);
  endtask

  vec_t        vecs[8];
  vec_t        v;
  logic [71:0] rd;
  logic [31:0] a, d;
  logic [7:0]  op;
  int          kind;

  initial begin
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    mem_arr[32'h400] = 32'h12345678;

    //         cmd                                  n  dly stl tx             ntx run       txn addr          wdata          wstrb
    vecs[0] = '{mk_write(32'h10, 32'hDEADBEEF),     9, 3,  0,  32'h06,        1,  4,        1,  32'h10,       32'hDEADBEEF,  4'hF};
    vecs[1] = '{mk_read(32'h400),                   5, 2,  1,  32'h12345678,  4,  3,        1,  32'h400,      32'h0,         4'h0};
    vecs[2] = '{{64'h0, 8'h41},                     1, 0,  0,  32'h15,        1,  0,        0,  32'h0,        32'h0,         4'h0};
    vecs[3] = '{mk_read(32'h10),                    5, 0,  1,  32'hDEADBEEF,  4,  1,        1,  32'h10,       32'h0,         4'h0};
    vecs[4] = '{mk_read(32'h2),                     5, 0,  0,  32'h15,        1,  0,        0,  32'h0,        32'h0,         4'h0};
    vecs[5] = '{mk_read(32'h20),                    5, -1, 1,  32'h15,        1,  TIMEOUT,  0,  32'h0,        32'h0,         4'h0};
    vecs[6] = '{mk_read(32'h8),                     5, 1,  0,  32'hFFFFFFF7,  4,  2,        1,  32'h8,        32'h0,         4'h0};
    vecs[7] = '{mk_write(32'hFFFFFFFC, 32'h0BADF00D), 9, 0, 1, 32'h06,        1,  1,        1,  32'hFFFFFFFC, 32'h0BADF00D,  4'hF};

    repeat (3) @(negedge clk);
    check("rst mem_valid", {31'h0, bif.mem_valid}, 32'h0);
    check("rst mem_addr",  bif.mem_addr, 32'h0);
    check("rst mem_wdata", bif.mem_wdata, 32'h0);
    check("rst mem_wstrb", {28'h0, bif.mem_wstrb}, 32'h0);
    check("rst tx_valid",  {31'h0, bif.tx_valid}, 32'h0);
    check("rst tx_data",   {24'h0, bif.tx_data}, 32'h0);
    check("rst busy",      {31'h0, busy}, 32'h0);
    check("rst overrun",   {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Overrun: a byte during the bus cycle is dropped, transaction still completes
    tx_q.delete();
    ready_delay = 4;
    stall       = 1'b0;
    rd          = mk_read(32'h30);
    for (int i = 0; i < 5; i++) send_byte(rd[8*i +: 8]);
    @(negedge clk);
    check("ovr in_bus", {31'h0, bif.mem_valid}, 32'h1);
    send_byte(8'h41);
    check("ovr set", {31'h0, overrun}, 32'h1);
    wait_idle("ovr");
    repeat (3) @(negedge clk);
    check("ovr ntx", tx_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < tx_q.size(); i++)
      check($sformatf("ovr tx%0d", i), {24'h0, tx_q[i]}, (i == 0) ? 32'hCF : 32'hFF);
    check("ovr sticky", {31'h0, overrun}, 32'h1);

    // Reset in the middle of a stalled bus cycle
    ready_delay = -1;
    rd          = mk_read(32'h40);
    for (int i = 0; i < 5; i++) send_byte(rd[8*i +: 8]);
    repeat (3) @(negedge clk);
    check("rstbus valid_before", {31'h0, bif.mem_valid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rstbus mem_valid", {31'h0, bif.mem_valid}, 32'h0);
    check("rstbus busy",      {31'h0, busy}, 32'h0);
    check("rstbus tx_valid",  {31'h0, bif.tx_valid}, 32'h0);
    check("rstbus overrun",   {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(vecs[2], "post_rst_bad");
    run_cmd(vecs[6], "post_rst_read");

    // Random commands against the reference model, in a disjoint address window
    for (int k = 0; k < 40; k++) begin
      kind    = $urandom_range(0, 9);
      a       = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      d       = $urandom();
      v.delay = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      v.stall = 1'($urandom_range(0, 1));
      v.tx    = {24'h0, RSP_NAK};
      v.ntx   = 1;
      v.run   = 0;
      v.txn   = 1'b0;
      v.addr  = a;
      v.wdata = d;
      v.wstrb = 4'h0;
      if (kind < 4 || kind == 9) begin
        if (kind == 9) a = a | 32'($urandom_range(1, 3));
        v.cmd  = mk_read(a);
        v.ncmd = 5;
        if (kind == 9) begin
          v.run = 0;
        end else if (v.delay < 0) begin
          v.run = TIMEOUT;
        end else begin
          v.run = v.delay + 1;
          v.txn = 1'b1;
          v.tx  = model_get(a);
          v.ntx = 4;
        end
      end else if (kind < 8) begin
        v.cmd   = mk_write(a, d);
        v.ncmd  = 9;
        v.wstrb = 4'hF;
        if (v.delay < 0) begin
          v.run = TIMEOUT;
        end else begin
          v.run = v.delay + 1;
          v.txn = 1'b1;
          v.tx  = {24'h0, RSP_ACK};
          model_mem[a] = d;
        end
      end else begin
        op = 8'($urandom_range(0, 255));
        if (op == OP_READ || op == OP_WRITE) op = 8'h00;
        v.cmd  = {64'h0, op};
        v.ncmd = 1;
      end
      run_cmd(v, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
